port_b_handshake: RTL

Port B mode-1 strobed I/O controller for the 8255 PPI. It sits directly downstream of the group B control-word decoder and consumes its port B direction, mode and BSR decode. It owns the port B data latch, the PC0–PC2 handshake pins (STB/ACK, IBF/OBF, INTR) and the INTE_B flag. In mode 0 it degrades to a plain latched/pass-through port.

---
 rtl/ppi_pkg.sv | 42 ++++
 rtl/ppi_edge_sync.sv | 50 +++++
 rtl/port_b_handshake.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ppi_pkg.sv
// Shared 8255 PPI constants: control-word fields, BSR codes, port C roles, reset values.
// PORTB_SYNC_EN selects a 2-flop pin synchronizer instead of a single sampling flop.
package ppi_pkg;

  localparam int MODE_FLAG = 7;
  localparam int GB_MODE   = 2;
  localparam int PB_DIR    = 1;
  localparam int PCL_DIR   = 0;

  localparam logic [2:0] BSR_SEL_PC2 = 3'b010;

  localparam int PC_INTR_B    = 0;
  localparam int PC_IBF_OBF_B = 1;
  localparam int PC_STB_ACK_B = 2;

  localparam logic RST_IBF   = 1'b0;
  localparam logic RST_OBF_N = 1'b1;
  localparam logic RST_INTR  = 1'b0;
  localparam logic RST_INTE  = 1'b0;
  localparam logic RST_PIN   = 1'b1;

`ifdef PORTB_SYNC_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 1;
`endif

  typedef struct packed {
    logic inte;
    logic hs;
    logic intr;
  } pc_lo_stat_t;

  function automatic pc_lo_stat_t pack_pc_lo(input logic inte, input logic hs, input logic intr);
    pc_lo_stat_t s;
    s.inte = inte;
    s.hs   = hs;
    s.intr = intr;
    return s;
  endfunction

endpackage

// File: rtl/ppi_edge_sync.sv
// Pin synchronizer (depth from ppi_pkg, set by PORTB_SYNC_EN) with registered rise/fall pulses.
module ppi_edge_sync
  import ppi_pkg::*;
#(
  parameter int DEPTH = SYNC_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [DEPTH-1:0] sync_q, sync_d;
  logic             prev_q, prev_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             level;

  assign level = sync_q[DEPTH-1];

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = level;
    rise_d = level & ~prev_q;
    fall_d = ~level & prev_q;
  end

  // Idle-high reset so a released reset never fabricates an edge on a quiet pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {DEPTH{RST_PIN}};
      prev_q <= RST_PIN;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/port_b_handshake.sv
// 8255 port B controller: mode 0 plain port, mode 1 strobed input/output with STB/ACK, IBF/OBF, INTR.
// PORTB_SYNC_EN adds a second synchronizer stage on stb_ack_n and pb_in.
module port_b_handshake
  import ppi_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ctrl_wr,
  input  logic          mode1,
  input  logic          pb_out_dir,
  input  logic          bsr_wr,
  input  logic [2:0]    bsr_sel,
  input  logic          bsr_val,
  input  logic          wr_pb,
  input  logic          rd_pb,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  input  logic [DW-1:0] pb_in,
  output logic [DW-1:0] pb_out,
  output logic          pb_oe,
  input  logic          stb_ack_n,
  output logic          pc1_hs,
  output logic          pc0_intr,
  output logic          hs_oe,
  output logic [2:0]    pc_lo_stat
);

  logic stb_rise, stb_fall;

  ppi_edge_sync #(.DEPTH(SYNC_DEPTH)) u_stb_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (stb_ack_n),
    .rise (stb_rise),
    .fall (stb_fall)
  );

  // Data follows the strobe pipeline one stage longer, matching the registered edge pulse.
  logic [DW-1:0] pb_sync_q [SYNC_DEPTH];
  logic [DW-1:0] pb_sync_d [SYNC_DEPTH];
  logic [DW-1:0] pb_dly_q, pb_dly_d;

  logic [DW-1:0] pb_out_q, pb_out_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0] latch_q, latch_d;
  logic          pb_oe_q, pb_oe_d;
  logic          mode1_q, mode1_d;
  logic          ibf_q, ibf_d;
  logic          obf_n_q, obf_n_d;
  logic          intr_q, intr_d;
  logic          inte_q, inte_d;

  always_comb begin
    pb_sync_d[0] = pb_in;
    for (int i = 1; i < SYNC_DEPTH; i++) begin
      pb_sync_d[i] = pb_sync_q[i-1];
    end
    pb_dly_d = pb_sync_q[SYNC_DEPTH-1];
  end

  always_comb begin
    pb_out_d  = pb_out_q;
    rd_data_d = rd_data_q;
    latch_d   = latch_q;
    pb_oe_d   = pb_oe_q;
    mode1_d   = mode1_q;
    ibf_d     = ibf_q;
    obf_n_d   = obf_n_q;
    intr_d    = intr_q;
    inte_d    = inte_q;

    if (ctrl_wr) begin
      pb_out_d  = '0;
      rd_data_d = '0;
      latch_d   = '0;
      pb_oe_d   = pb_out_dir;
      mode1_d   = mode1;
      ibf_d     = RST_IBF;
      obf_n_d   = RST_OBF_N;
      intr_d    = RST_INTR;
      inte_d    = RST_INTE;
    end else begin
      if (bsr_wr && (bsr_sel == BSR_SEL_PC2)) begin
        inte_d = bsr_val;
      end

      if (!mode1_q) begin
        if (wr_pb) pb_out_d = wr_data;
        if (rd_pb) rd_data_d = pb_in;
      end else if (!pb_oe_q) begin
        // Ordering gives the read's clear priority over a rise, and a new fall priority over the read.
        if (wr_pb) pb_out_d = wr_data;
        if (stb_rise && ibf_q) intr_d = 1'b1;
        if (rd_pb) begin
          rd_data_d = latch_q;
          ibf_d     = 1'b0;
          intr_d    = 1'b0;
        end
        if (stb_fall) begin
          latch_d = pb_dly_q;
          ibf_d   = 1'b1;
        end
      end else begin
        if (stb_fall) obf_n_d = 1'b1;
        if (stb_rise && obf_n_q) intr_d = 1'b1;
        if (wr_pb) begin
          pb_out_d = wr_data;
          obf_n_d  = 1'b0;
          intr_d   = 1'b0;
        end
        if (rd_pb) rd_data_d = pb_out_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_DEPTH; i++) begin
        pb_sync_q[i] <= '0;
      end
      pb_dly_q  <= '0;
      pb_out_q  <= '0;
      rd_data_q <= '0;
      latch_q   <= '0;
      pb_oe_q   <= 1'b0;
      mode1_q   <= 1'b0;
      ibf_q     <= RST_IBF;
      obf_n_q   <= RST_OBF_N;
      intr_q    <= RST_INTR;
      inte_q    <= RST_INTE;
    end else begin
      pb_sync_q <= pb_sync_d;
      pb_dly_q  <= pb_dly_d;
      pb_out_q  <= pb_out_d;
      rd_data_q <= rd_data_d;
      latch_q   <= latch_d;
      pb_oe_q   <= pb_oe_d;
      mode1_q   <= mode1_d;
      ibf_q     <= ibf_d;
      obf_n_q   <= obf_n_d;
      intr_q    <= intr_d;
      inte_q    <= inte_d;
    end
  end

  assign pb_out     = pb_out_q;
  assign pb_oe      = pb_oe_q;
  assign rd_data    = rd_data_q;
  assign hs_oe      = mode1_q;
  assign pc1_hs     = pb_oe_q ? obf_n_q : ibf_q;
  assign pc0_intr   = intr_q & inte_q;
  assign pc_lo_stat = pack_pc_lo(inte_q, pc1_hs, pc0_intr);

endmodule
